// File: rtl/ball_engine.sv
// Ball motion, wall/goal handling, scoring and match-flow FSM for the Pong engine.
// Optional build macro: BALL_ENGINE_WIN_BY_TWO_EN (win needs a 2-point lead).
module ball_engine #(
  parameter int H_VIDEO         = 640,
  parameter int V_VIDEO         = 480,
  parameter int SQ_WIDTH        = 16,
  parameter int CLK_HZ          = 25_175_000,
  parameter int VEL_WIDTH       = 10,
  parameter int MAX_SCORE       = 11,
  parameter int SCORE_WIDTH     = 4,
  parameter int SERVE_DELAY_CYC = 50_350_000,
  parameter int SAFE_START_CYC  = 2_500_000,
  parameter int Y_MIN           = 100,
  parameter int Y_MAX           = 380
) (
  input  logic                   clk_0,
  input  logic                   rst,
  input  logic                   btn_any,
  input  logic [VEL_WIDTH-1:0]   x_vel,
  input  logic [VEL_WIDTH-1:0]   y_vel,
  input  logic                   bounce_x,
  input  logic                   set_ydir_vld,
  input  logic                   set_ydir,
  output logic [9:0]             sq_xpos,
  output logic [9:0]             sq_ypos,
  output logic                   sq_xdir,
  output logic                   sq_ydir,
  output logic                   sq_shown,
  output logic [SCORE_WIDTH-1:0] score_p1,
  output logic [SCORE_WIDTH-1:0] score_p2,
  output logic [1:0]             state,
  output logic                   point_p1,
  output logic                   point_p2
);

  localparam int ACC_W  = $clog2(CLK_HZ + 2**VEL_WIDTH);
  localparam int LOCK_W = $clog2(SAFE_START_CYC + 1);
  localparam int DLY_W  = $clog2(SERVE_DELAY_CYC + 1);

  localparam logic [9:0]             X_HOME    = 10'(H_VIDEO / 2);
  localparam logic [9:0]             Y_HOME    = 10'(V_VIDEO / 2);
  localparam logic [9:0]             X_GOAL    = 10'(H_VIDEO - SQ_WIDTH - 1);
  localparam logic [9:0]             Y_BOT     = 10'(V_VIDEO - SQ_WIDTH - 1);
  localparam logic [9:0]             ROW_MIN   = 10'(Y_MIN);
  localparam logic [9:0]             ROW_MAX   = 10'(Y_MAX);
  localparam logic [ACC_W-1:0]       ACC_TH    = ACC_W'(CLK_HZ);
  localparam logic [LOCK_W-1:0]      LOCK_MAX  = LOCK_W'(SAFE_START_CYC);
  localparam logic [DLY_W-1:0]       DLY_LAST  = DLY_W'(SERVE_DELAY_CYC - 1);
  localparam logic [SCORE_WIDTH-1:0] MAX_SC    = SCORE_WIDTH'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_SERVE   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [9:0]               xpos_d, ypos_d, row_q, row_d;
  logic                     xdir_d, ydir_d, shown_d, pp1_d, pp2_d;
  logic                     row_up_q, row_up_d, armed_q, armed_d, spawn;
  logic [SCORE_WIDTH-1:0]   sc1_d, sc2_d, sc1_inc, sc2_inc;
  logic [ACC_W-1:0]         acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_x_nx, acc_y_nx;
  logic [LOCK_W-1:0]        lock_q, lock_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic                     x_step, y_step, p1_win, p2_win;

  assign state    = state_q;
  assign x_step   = acc_x_q >= ACC_TH;
  assign y_step   = acc_y_q >= ACC_TH;
  assign acc_x_nx = x_step ? acc_x_q - ACC_TH + ACC_W'(x_vel) : acc_x_q + ACC_W'(x_vel);
  assign acc_y_nx = y_step ? acc_y_q - ACC_TH + ACC_W'(y_vel) : acc_y_q + ACC_W'(y_vel);
  assign sc1_inc  = score_p1 + SCORE_WIDTH'(1);
  assign sc2_inc  = score_p2 + SCORE_WIDTH'(1);

`ifdef BALL_ENGINE_WIN_BY_TWO_EN
  // A score pinned at all-ones ends the match so the counter can never wrap.
  assign p1_win = (sc1_inc >= MAX_SC && {1'b0, sc1_inc} >= {1'b0, score_p2} + 2'd2) || (sc1_inc == '1);
  assign p2_win = (sc2_inc >= MAX_SC && {1'b0, sc2_inc} >= {1'b0, score_p1} + 2'd2) || (sc2_inc == '1);
`else
  assign p1_win = sc1_inc == MAX_SC;
  assign p2_win = sc2_inc == MAX_SC;
`endif

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_STARTUP;
      sq_xpos  <= X_HOME;
      sq_ypos  <= Y_HOME;
      sq_xdir  <= 1'b0;
      sq_ydir  <= 1'b0;
      sq_shown <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      lock_q   <= '0;
      dly_q    <= '0;
      row_q    <= ROW_MIN;
      row_up_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sq_xpos  <= xpos_d;
      sq_ypos  <= ypos_d;
      sq_xdir  <= xdir_d;
      sq_ydir  <= ydir_d;
      sq_shown <= shown_d;
      score_p1 <= sc1_d;
      score_p2 <= sc2_d;
      point_p1 <= pp1_d;
      point_p2 <= pp2_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      lock_q   <= lock_d;
      dly_q    <= dly_d;
      row_q    <= row_d;
      row_up_q <= row_up_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    xpos_d   = sq_xpos;
    ypos_d   = sq_ypos;
    xdir_d   = sq_xdir;
    ydir_d   = sq_ydir;
    shown_d  = sq_shown;
    sc1_d    = score_p1;
    sc2_d    = score_p2;
    pp1_d    = 1'b0;
    pp2_d    = 1'b0;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    lock_d   = lock_q;
    dly_d    = dly_q;
    row_d    = row_q;
    row_up_d = row_up_q;
    armed_d  = armed_q;
    spawn    = 1'b0;

    if (row_up_q) begin
      row_d = row_q + 10'd1;
      if (row_q + 10'd1 >= ROW_MAX) row_up_d = 1'b0;
    end else begin
      row_d = row_q - 10'd1;
      if (row_q - 10'd1 <= ROW_MIN) row_up_d = 1'b1;
    end

    if (lock_q != LOCK_MAX) lock_d = lock_q + LOCK_W'(1);

    unique case (state_q)
      ST_STARTUP: begin
        if (lock_q == LOCK_MAX && btn_any) begin
          spawn   = 1'b1;
          xdir_d  = 1'b0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (dly_q == DLY_LAST) begin
          shown_d = 1'b1;
          state_d = ST_PLAY;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_PLAY: begin
        // Free motion first; wall and paddle nudges below replace the step on their axis.
        acc_x_d = acc_x_nx;
        acc_y_d = acc_y_nx;
        if (x_step) xpos_d = sq_xdir ? sq_xpos + 10'd1 : sq_xpos - 10'd1;
        if (y_step) ypos_d = sq_ydir ? sq_ypos + 10'd1 : sq_ypos - 10'd1;
        if (sq_xpos >= X_GOAL) begin
          sc1_d   = sc1_inc;
          pp1_d   = 1'b1;
          spawn   = 1'b1;
          xdir_d  = 1'b1;
          armed_d = 1'b0;
          state_d = p1_win ? ST_OVER : ST_SERVE;
        end else if (sq_xpos == '0) begin
          sc2_d   = sc2_inc;
          pp2_d   = 1'b1;
          spawn   = 1'b1;
          xdir_d  = 1'b0;
          armed_d = 1'b0;
          state_d = p2_win ? ST_OVER : ST_SERVE;
        end else if (sq_ypos >= Y_BOT) begin
          ydir_d = 1'b0;
          ypos_d = sq_ypos - 10'd1;
        end else if (sq_ypos == '0) begin
          ydir_d = 1'b1;
          ypos_d = sq_ypos + 10'd1;
        end else begin
          if (bounce_x) begin
            xdir_d = ~sq_xdir;
            xpos_d = sq_xdir ? sq_xpos - 10'd1 : sq_xpos + 10'd1;
          end
          if (set_ydir_vld) ydir_d = set_ydir;
        end
      end
      ST_OVER: begin
        if (!btn_any) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          sc1_d   = '0;
          sc2_d   = '0;
          spawn   = 1'b1;
          xdir_d  = 1'b0;
          armed_d = 1'b0;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (spawn) begin
      xpos_d  = X_HOME;
      ypos_d  = row_q;
      ydir_d  = row_q[0];
      acc_x_d = '0;
      acc_y_d = '0;
      shown_d = 1'b0;
      dly_d   = '0;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a cycle model pushes expected outputs, each scenario pops and compares.
module tb_ball_engine;

  localparam int H     = 640;
  localparam int V     = 480;
  localparam int SQ    = 16;
  localparam int CLK   = 1000;
  localparam int VW    = 10;
  localparam int MAXS  = 11;
  localparam int SW    = 4;
  localparam int SERVE = 10;
  localparam int SAFE  = 20;
  localparam int YMIN  = 100;
  localparam int YMAX  = 380;

  logic          clk_0 = 1'b0;
  logic          rst = 1'b0;
  logic          btn_any = 1'b0;
  logic [VW-1:0] x_vel = '0;
  logic [VW-1:0] y_vel = '0;
  logic          bounce_x = 1'b0;
  logic          set_ydir_vld = 1'b0;
  logic          set_ydir = 1'b0;
  logic [9:0]    sq_xpos, sq_ypos;
  logic          sq_xdir, sq_ydir, sq_shown;
  logic [SW-1:0] score_p1, score_p2;
  logic [1:0]    state;
  logic          point_p1, point_p2;

  ball_engine #(
    .H_VIDEO(H), .V_VIDEO(V), .SQ_WIDTH(SQ), .CLK_HZ(CLK), .VEL_WIDTH(VW),
    .MAX_SCORE(MAXS), .SCORE_WIDTH(SW), .SERVE_DELAY_CYC(SERVE),
    .SAFE_START_CYC(SAFE), .Y_MIN(YMIN), .Y_MAX(YMAX)
  ) dut (
    .clk_0(clk_0), .rst(rst), .btn_any(btn_any), .x_vel(x_vel), .y_vel(y_vel),
    .bounce_x(bounce_x), .set_ydir_vld(set_ydir_vld), .set_ydir(set_ydir),
    .sq_xpos(sq_xpos), .sq_ypos(sq_ypos), .sq_xdir(sq_xdir), .sq_ydir(sq_ydir),
    .sq_shown(sq_shown), .score_p1(score_p1), .score_p2(score_p2), .state(state),
    .point_p1(point_p1), .point_p2(point_p2)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct packed {
    logic [1:0]    st;
    logic [9:0]    x, y;
    logic          xd, yd, sh;
    logic [SW-1:0] s1, s2;
    logic          p1, p2;
  } snap_t;

  snap_t exp_q[$];
  snap_t e, o;
  int checks = 0;
  int errors = 0;
  int cyc;

  always @(posedge clk_0 or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Reference model of the engine, kept in plain integers.
  int mst, mx, my, mxd, myd, msh, ms1, ms2, mp1, mp2, macx, macy, mdly, marmed;

  function automatic int row_at(int n);
    int span = YMAX - YMIN;
    int p = n % (2 * span);
    return (p <= span) ? YMIN + p : YMIN + 2 * span - p;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d x=%0d y=%0d xd=%0d yd=%0d sh=%0d sc=%0d:%0d pt=%0d%0d",
                     s.st, s.x, s.y, s.xd, s.yd, s.sh, s.s1, s.s2, s.p1, s.p2);
  endfunction

  function automatic snap_t obs();
    return '{state, sq_xpos, sq_ypos, sq_xdir, sq_ydir, sq_shown, score_p1, score_p2, point_p1, point_p2};
  endfunction

  function automatic snap_t snap_m();
    return '{2'(mst), 10'(mx), 10'(my), 1'(mxd), 1'(myd), 1'(msh), SW'(ms1), SW'(ms2), 1'(mp1), 1'(mp2)};
  endfunction

  function automatic bit wins(int mine, int other);
`ifdef BALL_ENGINE_WIN_BY_TWO_EN
    return (mine >= MAXS && mine - other >= 2) || mine == (1 << SW) - 1;
`else
    return mine == MAXS;
`endif
  endfunction

  task automatic model_reset();
    mst = 0; mx = H / 2; my = V / 2; mxd = 0; myd = 0; msh = 0;
    ms1 = 0; ms2 = 0; mp1 = 0; mp2 = 0; macx = 0; macy = 0; mdly = 0; marmed = 0;
  endtask

  task automatic m_spawn(int row, int dir);
    mx = H / 2; my = row; myd = row & 1; mxd = dir; macx = 0; macy = 0; msh = 0; mdly = 0;
  endtask

  task automatic model_step();
    int row, nx, ny, nacx, nacy;
    bit xs, ys;
    row = row_at(cyc);
    mp1 = 0; mp2 = 0;
    case (mst)
      0: if (cyc >= SAFE && btn_any) begin m_spawn(row, 0); mst = 1; end
      1: if (mdly == SERVE - 1) begin msh = 1; mst = 2; end else mdly++;
      2: begin
        xs = macx >= CLK;
        ys = macy >= CLK;
        nacx = xs ? macx - CLK + int'(x_vel) : macx + int'(x_vel);
        nacy = ys ? macy - CLK + int'(y_vel) : macy + int'(y_vel);
        nx = xs ? (mxd != 0 ? mx + 1 : mx - 1) : mx;
        ny = ys ? (myd != 0 ? my + 1 : my - 1) : my;
        if (mx >= H - SQ - 1) begin
          ms1++; mp1 = 1; m_spawn(row, 1); marmed = 0;
          mst = wins(ms1, ms2) ? 3 : 1;
        end else if (mx == 0) begin
          ms2++; mp2 = 1; m_spawn(row, 0); marmed = 0;
          mst = wins(ms2, ms1) ? 3 : 1;
        end else begin
          if (my >= V - SQ - 1) begin
            myd = 0; ny = my - 1;
          end else if (my == 0) begin
            myd = 1; ny = my + 1;
          end else begin
            if (bounce_x) begin mxd = (mxd == 0); nx = (mxd != 0) ? mx + 1 : mx - 1; end
            if (set_ydir_vld) myd = set_ydir;
          end
          mx = nx; my = ny; macx = nacx; macy = nacy;
        end
      end
      default: begin
        if (!btn_any) marmed = 1;
        else if (marmed != 0) begin
          ms1 = 0; ms2 = 0; m_spawn(row, 0); mst = 1; marmed = 0;
        end
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    exp_q.push_back(snap_m());
    @(posedge clk_0);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_0);
    #1;
    model_reset();
    exp_q.push_back(snap_m());
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge clk_0);
    rst = 1'b1;
  endtask

  task automatic test_startup();
    for (int k = 1; k <= SAFE + 1; k++) begin
      if (k == 10) btn_any = 1'b1;
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL startup[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
      if (k == SAFE) begin
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL lockout: got state %0d, expected 0", state); end
      end
    end
    checks++;
    if (state !== 2'd1 || sq_ypos !== 10'(YMIN + SAFE)) begin
      errors++; $display("FAIL first_press: got state %0d y %0d, expected 1 y %0d", state, sq_ypos, YMIN + SAFE);
    end
    btn_any = 1'b0;
  endtask

  task automatic test_serve();
    for (int k = 0; k < SERVE; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL serve[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
    end
    checks++;
    if (state !== 2'd2 || sq_shown !== 1'b1 || sq_xpos !== 10'd320) begin
      errors++; $display("FAIL serve_done: got st=%0d sh=%0d x=%0d, expected st=2 sh=1 x=320", state, sq_shown, sq_xpos);
    end
  endtask

  task automatic test_play_x();
    bit done = 0;
    x_vel = 10'd500;
    for (int k = 0; k < 1500 && !done; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL play_x[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
      if (mst == 1) done = 1;
    end
    if (!done) begin checks++; errors++; $display("FAIL play_x_timeout: got no goal, expected point_p2 within 1500 cycles"); end
    checks++;
    if (point_p2 !== 1'b1 || score_p2 !== 4'd1 || sq_xdir !== 1'b0) begin
      errors++; $display("FAIL goal_p2: got pt=%0d s2=%0d xd=%0d, expected 1 1 0", point_p2, score_p2, sq_xdir);
    end
    x_vel = '0;
  endtask

  task automatic test_wall();
    bit hit = 0;
    int after = 0;
    int yb;
    for (int k = 0; k < SERVE; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL wall_serve[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
    end
    y_vel = 10'd1000; set_ydir_vld = 1'b1; set_ydir = 1'b1;
    for (int k = 0; k < 600 && after < 5; k++) begin
      yb = my;
      cycle();
      set_ydir_vld = 1'b0;
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL wall[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
      if (hit) after++;
      if (!hit && yb >= V - SQ - 1) begin
        hit = 1; checks++;
        if (sq_ypos !== 10'(yb - 1) || sq_ydir !== 1'b0) begin
          errors++; $display("FAIL wall_hit: got y=%0d yd=%0d, expected y=%0d yd=0", sq_ypos, sq_ydir, yb - 1);
        end
      end
    end
    if (!hit) begin checks++; errors++; $display("FAIL wall_timeout: got no wall hit, expected one within 600 cycles"); end
  endtask

  task automatic test_bounce_goal();
    bit done = 0;
    bit armed_goal = 0;
    y_vel = '0; x_vel = 10'd1000; bounce_x = 1'b1;
    cycle();
    bounce_x = 1'b0;
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || sq_xdir !== 1'b1) begin errors++; $display("FAIL bounce: got %s, expected %s", fmt(o), fmt(e)); end
    for (int k = 0; k < 800 && !done; k++) begin
      if (mx == H - SQ - 1) begin bounce_x = 1'b1; armed_goal = 1; end
      cycle();
      bounce_x = 1'b0;
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL to_goal[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
      if (armed_goal) begin
        done = 1; checks++;
        if (state !== 2'd1 || score_p1 !== 4'd1 || point_p1 !== 1'b1 || sq_xdir !== 1'b1 || sq_xpos !== 10'd320) begin
          errors++; $display("FAIL goal_over_bounce: got %s, expected st=1 x=320 xd=1 s1=1 pt=10", fmt(o));
        end
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL bounce_goal_timeout: got no goal, expected one within 800 cycles"); end
  endtask

  task automatic test_win_over();
    bit done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (ms1 == MAXS - 1 && mst == 2) btn_any = 1'b1;
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL match[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
      if (mst == 3) done = 1;
    end
    if (!done) begin checks++; errors++; $display("FAIL match_timeout: got no game over, expected one within 5000 cycles"); end
    checks++;
    if (state !== 2'd3 || score_p1 !== 4'd11 || score_p2 !== 4'd1 || sq_shown !== 1'b0) begin
      errors++; $display("FAIL win: got %s, expected st=3 sc=11:1 sh=0", fmt(obs()));
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e || state !== 2'd3) begin errors++; $display("FAIL over_hold[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
    end
    btn_any = 1'b0;
    cycle();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL over_release: got %s, expected %s", fmt(o), fmt(e)); end
    btn_any = 1'b1;
    cycle();
    btn_any = 1'b0;
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || state !== 2'd1 || score_p1 !== '0 || score_p2 !== '0 || sq_xdir !== 1'b0) begin
      errors++; $display("FAIL restart: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL pre_reset[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(snap_m());
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge clk_0);
    rst = 1'b1;
    btn_any = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL relock[%0d]: got %s, expected %s", k, fmt(o), fmt(e)); end
    end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL relock_state: got state %0d, expected 0", state); end
    btn_any = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_serve();
    test_play_x();
    test_wall();
    test_bounce_goal();
    test_win_over();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
